// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - packs CPU instruction fields into 32-bit words and writes them bytewise to instruction memory
module instruction_loader #(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [7:0] OPCODE_MAX = 8'h05
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_opcode,
  input  logic [2:0]            in_dest,
  input  logic [2:0]            in_src1,
  input  logic [2:0]            in_src2,
  input  logic [7:0]            in_imm,
  input  logic                  in_last,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_writedata,
  input  logic                  mem_busywait,
  output logic [31:0]           instr_word,
  output logic [ADDR_WIDTH-2:0] instr_count,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Words are word-aligned, so the byte address is just {slot, byte index}.
  logic [ADDR_WIDTH-3:0] slot_q;
  logic [1:0]            idx_q;
  logic [31:0]           word_q;
  logic [ADDR_WIDTH-2:0] count_q;
  logic                  last_q;
  logic                  error_q;

  logic accept;
  logic illegal;
  logic byte_done;
  logic word_done;
  logic mem_full;

  function automatic logic [31:0] encode(
    input logic [7:0] op,
    input logic [2:0] dest,
    input logic [2:0] src1,
    input logic [2:0] src2,
    input logic [7:0] imm
  );
    logic [31:0] w;
    case (op)
      8'h00:   w = {op, 5'd0, dest, 8'h00, imm};
      8'h01:   w = {op, 5'd0, dest, 8'h00, 5'd0, src2};
      default: w = {op, 5'd0, dest, 5'd0, src1, 5'd0, src2};
    endcase
    return w;
  endfunction

  assign accept    = in_valid && (state_q == S_IDLE);
  assign illegal   = in_opcode > OPCODE_MAX;
  assign byte_done = (state_q == S_WRITE) && !mem_busywait;
  assign word_done = byte_done && (idx_q == 2'd3);
  // The slot being finished is the last one when incrementing would wrap to 0.
  assign mem_full  = &slot_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !illegal) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (word_done) state_d = (last_q || mem_full) ? S_DONE : S_IDLE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      idx_q   <= 2'd0;
      word_q  <= 32'h0;
      count_q <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (illegal) begin
          error_q <= 1'b1;
        end else begin
          word_q <= encode(in_opcode, in_dest, in_src1, in_src2, in_imm);
          idx_q  <= 2'd0;
          last_q <= in_last;
        end
      end
      if (byte_done) idx_q <= idx_q + 2'd1;
      if (word_done) begin
        slot_q  <= slot_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_write     = (state_q == S_WRITE);
  assign mem_addr      = {slot_q, idx_q};
  assign mem_writedata = (state_q == S_WRITE) ? word_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign instr_word    = word_q;
  assign instr_count   = count_q;
  assign cpu_hold      = (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign error         = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - self-checking bench for instruction_loader (default and 4-bit address instances)
module tb_instruction_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_opcode;
  logic [2:0]  in_dest, in_src1, in_src2;
  logic [7:0]  in_imm;
  logic        in_last;
  logic        mem_busywait;

  logic        in_ready, mem_write, cpu_hold, done, error;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_writedata;
  logic [31:0] instr_word;
  logic [8:0]  instr_count;

  logic        in_ready_s, mem_write_s, cpu_hold_s, done_s, error_s;
  logic [3:0]  mem_addr_s;
  logic [7:0]  mem_writedata_s;
  logic [31:0] instr_word_s;
  logic [2:0]  instr_count_s;

  instruction_loader #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
    .in_imm(in_imm), .in_last(in_last), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_writedata(mem_writedata), .mem_busywait(mem_busywait), .instr_word(instr_word),
    .instr_count(instr_count), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  instruction_loader #(.ADDR_WIDTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_opcode(in_opcode), .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
    .in_imm(in_imm), .in_last(in_last), .mem_write(mem_write_s), .mem_addr(mem_addr_s),
    .mem_writedata(mem_writedata_s), .mem_busywait(mem_busywait), .instr_word(instr_word_s),
    .instr_count(instr_count_s), .cpu_hold(cpu_hold_s), .done(done_s), .error(error_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed memory images, filled from the write strobes
  logic [7:0] obs   [0:1023];
  logic [7:0] obs_s [0:15];
  always @(posedge clk) begin
    if (mem_write && !mem_busywait)   obs[mem_addr]     <= mem_writedata;
    if (mem_write_s && !mem_busywait) obs_s[mem_addr_s] <= mem_writedata_s;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Reference model: list of words the loader should have stored, in order
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;
  int          exp_cnt;
  logic        exp_err;
  logic        model_done;
  bit          rand_busy = 0;

  function automatic logic [31:0] ref_encode(input logic [7:0] op, input logic [2:0] d,
                                             input logic [2:0] s1, input logic [2:0] s2,
                                             input logic [7:0] imm);
    logic [31:0] w;
    w = 32'(op) << 24 | 32'(d) << 16;
    if (op == 8'h00)      w = w | 32'(imm);
    else if (op == 8'h01) w = w | 32'(s2);
    else                  w = w | 32'(s1) << 8 | 32'(s2);
    return w;
  endfunction

  task automatic model_accept(input logic [7:0] op, input logic [2:0] d, input logic [2:0] s1,
                              input logic [2:0] s2, input logic [7:0] imm, input logic last);
    if (op <= 8'h05) begin
      exp_word = ref_encode(op, d, s1, s2, imm);
      exp_q.push_back(exp_word);
      exp_cnt++;
      model_done = last || (exp_cnt == 256);
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_writedata, 0);
    chk({tag, "_instr_word"}, instr_word, 0);
    chk({tag, "_instr_count"}, instr_count, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_s_ready"}, in_ready_s, 1);
    chk({tag, "_s_done"}, done_s, 0);
    chk({tag, "_s_hold"}, cpu_hold_s, 1);
    chk({tag, "_s_count"}, instr_count_s, 0);
    chk({tag, "_s_addr"}, mem_addr_s, 0);
  endtask

  task automatic do_reset(input string tag);
    in_valid = 0;
    mem_busywait = 0;
    rst_n = 0;
    #1;
    check_reset(tag);
    @(posedge clk); #1;
    rst_n = 1;
    exp_q.delete();
    exp_word = 0; exp_cnt = 0; exp_err = 0; model_done = 0;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [7:0] imm, input logic last);
    in_opcode = op; in_dest = d; in_src1 = s1; in_src2 = s2; in_imm = imm; in_last = last;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send(input logic [7:0] op, input logic [2:0] d, input logic [2:0] s1,
                      input logic [2:0] s2, input logic [7:0] imm, input logic last,
                      output int lat);
    int n = 0;
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    chk("ready_before_send", in_ready, 1);
    drive(op, d, s1, s2, imm, last);
    model_accept(op, d, s1, s2, imm, last);
    chk("instr_word", instr_word, exp_word);
    chk("error", error, exp_err);
    if (op > 8'h05) begin
      chk("drop_no_write", mem_write, 0);
      chk("drop_ready", in_ready, 1);
    end else begin
      chk("first_addr", mem_addr, 32'((exp_cnt - 1) * 4) & 32'h3ff);
      chk("first_data", mem_writedata, exp_word[7:0]);
    end
    lat = 0;
    while (!in_ready && !done && lat < 300) begin @(posedge clk); #1; lat++; end
    chk("instr_count", instr_count, exp_cnt);
    chk("done", done, model_done);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  d, s1, s2;
    logic [7:0]  imm;
    logic        last;
    logic [31:0] word;
    logic        err;
    int          lat;
  } vec_t;
  vec_t tbl[3];

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_busy) mem_busywait = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  initial begin
    int lat;
    int cyc;
    logic [7:0] op;
    logic [31:0] w;

    tbl[0] = '{8'h00, 3'd4, 3'd0, 3'd0, 8'h05, 1'b0, 32'h00040005, 1'b0, 4};
    tbl[1] = '{8'h02, 3'd6, 3'd4, 3'd2, 8'h00, 1'b0, 32'h02060402, 1'b0, 4};
    tbl[2] = '{8'h09, 3'd1, 3'd1, 3'd1, 8'hAA, 1'b1, 32'h02060402, 1'b1, 0};

    rst_n = 1; in_valid = 0; mem_busywait = 0;
    in_opcode = 0; in_dest = 0; in_src1 = 0; in_src2 = 0; in_imm = 0; in_last = 0;
    #2;
    do_reset("rst0");

    for (int i = 0; i < 3; i++) begin
      send(tbl[i].op, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].imm, tbl[i].last, lat);
      chk($sformatf("tbl%0d_word", i), instr_word, tbl[i].word);
      chk($sformatf("tbl%0d_err", i), error, tbl[i].err);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_done", i), done, 0);
    end
    chk("mem_word0", {obs[3], obs[2], obs[1], obs[0]}, 32'h00040005);
    chk("mem_word1", {obs[7], obs[6], obs[5], obs[4]}, 32'h02060402);

    // Stall on byte 2: address and data must hold for the whole stall
    drive(8'h03, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0);
    model_accept(8'h03, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0);
    chk("busy_word", instr_word, 32'h03010203);
    repeat (2) begin @(posedge clk); #1; end
    chk("busy_addr0", mem_addr, 10);
    chk("busy_data0", mem_writedata, 8'h01);
    mem_busywait = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("busy_addr_%0d", k), mem_addr, 10);
      chk($sformatf("busy_data_%0d", k), mem_writedata, 8'h01);
      chk($sformatf("busy_ready_%0d", k), in_ready, 0);
    end
    mem_busywait = 0;
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("busy_tail_cycles", cyc, 2);
    chk("busy_count", instr_count, 3);
    chk("busy_mem", {obs[11], obs[10], obs[9], obs[8]}, 32'h03010203);

    // Randomized tuples with random memory stalls
    rand_busy = 1;
    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(0, 5));
      send(op, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 1'b0, lat);
    end
    rand_busy = 0;
    @(posedge clk); #2;
    mem_busywait = 0;

    send(8'h01, 3'd0, 3'd5, 3'd6, 8'h77, 1'b1, lat);
    chk("mov_word", instr_word, 32'h01000006);
    chk("mov_lat", lat, 4);
    chk("mov_done", done, 1);
    chk("mov_hold", cpu_hold, 0);
    chk("mov_ready", in_ready, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      w = {obs[4*i+3], obs[4*i+2], obs[4*i+1], obs[4*i]};
      chk($sformatf("mem_slot%0d", i), w, exp_q[i]);
    end

    in_opcode = 8'h00; in_dest = 3'd7; in_imm = 8'hFF; in_last = 0; in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("done_ignore_write%0d", k), mem_write, 0);
    end
    in_valid = 0;
    chk("done_ignore_word", instr_word, 32'h01000006);
    chk("done_ignore_count", instr_count, exp_cnt);
    chk("done_sticky", done, 1);

    // Small memory: four instructions fill it and force completion
    do_reset("rst1");
    for (int i = 0; i < 4; i++) send(8'h00, 3'(i + 1), 3'd0, 3'd0, 8'(8'h10 + i), 1'b0, lat);
    chk("full_s_done", done_s, 1);
    chk("full_s_hold", cpu_hold_s, 0);
    chk("full_s_ready", in_ready_s, 0);
    chk("full_s_count", instr_count_s, 4);
    chk("full_s_write", mem_write_s, 0);
    chk("full_big_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      w = {obs_s[4*i+3], obs_s[4*i+2], obs_s[4*i+1], obs_s[4*i]};
      chk($sformatf("full_s_slot%0d", i), w, exp_q[i]);
    end

    // Asynchronous reset in the middle of a word
    drive(8'h04, 3'd2, 3'd3, 3'd4, 8'h00, 1'b0);
    @(posedge clk); #3;
    chk("mid_write_active", mem_write, 1);
    rst_n = 0;
    #1;
    check_reset("midrst");
    @(posedge clk); #1;
    rst_n = 1;
    exp_q.delete();
    exp_word = 0; exp_cnt = 0; exp_err = 0; model_done = 0;
    send(8'h05, 3'd3, 3'd1, 3'd7, 8'h00, 1'b0, lat);
    chk("restart_word", {obs[3], obs[2], obs[1], obs[0]}, 32'h05030107);
    chk("restart_lat", lat, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
